// File: rtl/mux_4to1_rr_collector_pkg.sv
// Shared definitions for the 4-to-1 round-robin collector: channel counts,
// arbiter state encoding and the rotating-priority pick function.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    // Returns {found, idx}: the first valid channel at or after ptr, wrapping mod 4.
    // Scanning from the far end means the nearest valid channel is written last and wins.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [NUM_CH-1:0] valid,
        input logic [SEL_W-1:0]  ptr
    );
        logic [SEL_W-1:0] cand;
        logic [SEL_W:0]   pick;
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (valid[cand]) begin
                pick = {1'b1, cand};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4to1_rr_collector_arbiter.sv
// Round-robin arbiter for four channels: combinational pick starting at the
// priority pointer, plus the pointer register that the collector advances.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] valid,
    input  logic              advance,
    input  logic [SEL_W-1:0]  base,
    output logic              found,
    output logic [SEL_W-1:0]  winner
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W:0]   pick;

    always_comb begin
        pick   = rr_pick(valid, ptr);
        found  = pick[SEL_W];
        winner = pick[SEL_W-1:0];
    end

    // Priority moves to the channel after the one just served; 3+1 wraps to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= base + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_4to1_rr_collector.sv
// Collects beats from four valid/ready source channels onto one registered
// output stream tagged with the source index, using round-robin with burst locking.
module mux_4to1_rr_collector
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BURST  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    arb_state_t       state;
    logic [SEL_W-1:0] cur;
    logic [3:0]       cnt;

    logic              load;
    logic              found;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  grant;
    logic              accept;
    logic              ptr_adv;
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] grant_data;

    rr_arbiter4 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (in_valid),
        .advance (ptr_adv),
        .base    (grant),
        .found   (found),
        .winner  (winner)
    );

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_data[c] = in_data[c*DATA_W +: DATA_W];
        end
    end

    // Only the granted channel may see ready, and only when the output slot can take a beat.
    always_comb begin
        load       = ~out_valid | out_ready;
        grant      = (state == IDLE) ? winner : cur;
        grant_data = ch_data[grant];
        in_ready   = '0;
        if (rst_n) begin
            if (state == IDLE) begin
                if (found) begin
                    in_ready[winner] = load;
                end
            end else begin
                in_ready[cur] = load;
            end
        end
        accept = |(in_valid & in_ready);
    end

    // Pointer rotation: after every beat when bursts are disabled, otherwise
    // when a burst is exhausted or the locked channel drops its valid.
    always_comb begin
        ptr_adv = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (BURST == 1 && accept) begin
                        ptr_adv = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!in_valid[cur]) begin
                        ptr_adv = 1'b1;
                    end else if (accept && cnt == 4'(BURST - 1)) begin
                        ptr_adv = 1'b1;
                    end
                end
                default: ptr_adv = 1'b0;
            endcase
        end
    end

    // Output register and burst FSM; a new beat may load in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            if (accept) begin
                out_data  <= grant_data;
                out_sel   <= grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && BURST > 1) begin
                        cur   <= winner;
                        cnt   <= 4'd1;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (!in_valid[cur]) begin
                        state <= IDLE;
                    end else if (accept) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'(BURST - 1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4to1_rr_collector.sv
// Scoreboard bench for the 4-to-1 round-robin collector (BURST=2 main instance,
// plus a BURST=1 instance observed for rotation without burst locking).
module tb_mux_4to1_rr_collector;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_valid;
    logic [3:0]          in_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_valid;
    logic                out_ready;

    logic [3:0]          b1_in_ready;
    logic [DATA_W-1:0]   b1_out_data;
    logic [1:0]          b1_out_sel;
    logic                b1_out_valid;

    mux_4to1_rr_collector #(.DATA_W(DATA_W), .BURST(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_4to1_rr_collector #(.DATA_W(DATA_W), .BURST(1)) dut_b1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (b1_in_ready),
        .out_data  (b1_out_data),
        .out_sel   (b1_out_sel),
        .out_valid (b1_out_valid),
        .out_ready (1'b1)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [9:0] sb[$];
    logic [9:0] sb_b1[$];

    int         src_left [4];
    logic [7:0] src_data [4];
    logic [7:0] src_step [4];

    logic [3:0] in_fire;
    logic [3:0] obs_ready;
    logic       out_fire;
    logic       obs_valid;
    logic [1:0] obs_sel;
    logic [7:0] obs_data;
    logic       b1_fire;
    logic [1:0] b1_sel;
    logic [7:0] b1_data;

    // Source model: each channel offers beats while it has any left.
    task automatic drive_inputs();
        for (int c = 0; c < 4; c++) begin
            in_valid[c] = (src_left[c] > 0);
            in_data[c*DATA_W +: DATA_W] = src_data[c];
        end
    endtask

    task automatic clear_sources();
        for (int c = 0; c < 4; c++) begin
            src_left[c] = 0;
            src_data[c] = 8'h00;
            src_step[c] = 8'h01;
        end
    endtask

    // Samples handshakes mid-cycle, advances one clock, then updates the sources.
    task automatic tick();
        #4;
        obs_ready = in_ready;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        obs_valid = out_valid;
        obs_sel   = out_sel;
        obs_data  = out_data;
        b1_fire   = b1_out_valid;
        b1_sel    = b1_out_sel;
        b1_data   = b1_out_data;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            if (in_fire[c]) begin
                src_left[c] = src_left[c] - 1;
                src_data[c] = src_data[c] + src_step[c];
            end
        end
        drive_inputs();
    endtask

    task automatic apply_reset();
        clear_sources();
        out_ready = 1'b1;
        rst_n = 1'b0;
        drive_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        sb.delete();
        sb_b1.delete();
    endtask

    task automatic test_reset();
        int acc_cyc;
        logic [9:0] exp;
        clear_sources();
        for (int c = 0; c < 4; c++) src_left[c] = 3;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive_inputs();
        repeat (2) begin
            tick();
            total_cnt++;
            if (obs_ready !== 4'b0000) $display("[TB] FAIL reset_in_ready: got %b, expected 0000", obs_ready);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 8'h00) $display("[TB] FAIL reset_out_data: got %h, expected 00", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_sel !== 2'd0) $display("[TB] FAIL reset_out_sel: got %0d, expected 0", out_sel);
        else pass_cnt++;

        clear_sources();
        src_left[2] = 1;
        src_data[2] = 8'hA5;
        rst_n = 1'b1;
        drive_inputs();
        sb.push_back({2'd2, 8'hA5});
        acc_cyc = -100;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            tick();
            if (in_fire[2]) acc_cyc = cyc;
            if (out_fire) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({obs_sel, obs_data} !== exp)
                    $display("[TB] FAIL single_beat: got sel=%0d data=%h, expected sel=%0d data=%h", obs_sel, obs_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
                total_cnt++;
                if (cyc - acc_cyc !== 1) $display("[TB] FAIL single_latency: got %0d cycles, expected 1", cyc - acc_cyc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL single_timeout: %0d beats missing, expected 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [9:0] exp;
        logic [1:0] s;
        int first_b1;
        int n_b1;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            src_left[c] = 1000;
            src_data[c] = 8'h10 + 8'(c);
            src_step[c] = 8'h00;
        end
        drive_inputs();
        for (int i = 0; i < 10; i++) begin
            s = 2'((i / 2) % 4);
            sb.push_back({s, 8'h10 + {6'd0, s}});
        end
        for (int i = 0; i < 5; i++) begin
            s = 2'(i % 4);
            sb_b1.push_back({s, 8'h10 + {6'd0, s}});
        end
        first_b1 = 0;
        n_b1 = 0;
        for (int i = 0; i < 60 && (sb.size() > 0 || sb_b1.size() > 0); i++) begin
            tick();
            if (out_fire && sb.size() > 0) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({obs_sel, obs_data} !== exp)
                    $display("[TB] FAIL fair_burst2: got sel=%0d data=%h, expected sel=%0d data=%h", obs_sel, obs_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
            end
            if (b1_fire && sb_b1.size() > 0) begin
                exp = sb_b1.pop_front();
                total_cnt++;
                if ({b1_sel, b1_data} !== exp)
                    $display("[TB] FAIL fair_burst1: got sel=%0d data=%h, expected sel=%0d data=%h", b1_sel, b1_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
                if (n_b1 == 0) first_b1 = cyc;
                n_b1++;
                if (n_b1 == 5) begin
                    total_cnt++;
                    if (cyc - first_b1 !== 4) $display("[TB] FAIL fair_burst1_rate: got %0d cycles for 5 beats, expected 4", cyc - first_b1);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (sb.size() != 0 || sb_b1.size() != 0)
            $display("[TB] FAIL fair_timeout: %0d/%0d beats missing, expected 0/0", sb.size(), sb_b1.size());
        else pass_cnt++;
    endtask

    task automatic test_early_release();
        logic [9:0] exp;
        int n;
        int prev;
        apply_reset();
        src_left[1] = 1;
        src_data[1] = 8'h21;
        src_left[3] = 100;
        src_data[3] = 8'h30;
        drive_inputs();
        sb.push_back({2'd1, 8'h21});
        sb.push_back({2'd3, 8'h30});
        sb.push_back({2'd3, 8'h31});
        sb.push_back({2'd3, 8'h32});
        n = 0;
        prev = 0;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            tick();
            if (out_fire) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({obs_sel, obs_data} !== exp)
                    $display("[TB] FAIL early_release: got sel=%0d data=%h, expected sel=%0d data=%h", obs_sel, obs_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
                if (n == 1) begin
                    total_cnt++;
                    if (cyc - prev !== 2) $display("[TB] FAIL release_bubble: got gap %0d, expected 2", cyc - prev);
                    else pass_cnt++;
                end
                prev = cyc;
                n++;
            end
        end
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL early_timeout: %0d beats missing, expected 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        apply_reset();
        src_left[0] = 3;
        src_data[0] = 8'h00;
        src_left[1] = 3;
        src_data[1] = 8'h40;
        out_ready = 1'b0;
        drive_inputs();
        sb.push_back({2'd0, 8'h00});
        sb.push_back({2'd0, 8'h01});
        sb.push_back({2'd1, 8'h40});
        sb.push_back({2'd1, 8'h41});
        sb.push_back({2'd0, 8'h02});
        sb.push_back({2'd1, 8'h42});
        tick();
        repeat (3) begin
            tick();
            total_cnt++;
            if (obs_ready !== 4'b0000) $display("[TB] FAIL bp_in_ready: got %b, expected 0000", obs_ready);
            else pass_cnt++;
            total_cnt++;
            if ({obs_valid, obs_sel, obs_data} !== {1'b1, 2'd0, 8'h00})
                $display("[TB] FAIL bp_hold: got valid=%b sel=%0d data=%h, expected valid=1 sel=0 data=00", obs_valid, obs_sel, obs_data);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            tick();
            if (out_fire) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({obs_sel, obs_data} !== exp)
                    $display("[TB] FAIL bp_drain: got sel=%0d data=%h, expected sel=%0d data=%h", obs_sel, obs_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL bp_timeout: %0d beats missing, expected 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_wrap_around();
        logic [9:0] exp;
        apply_reset();
        src_left[2] = 1;
        src_data[2] = 8'h2A;
        drive_inputs();
        sb.push_back({2'd2, 8'h2A});
        sb.push_back({2'd3, 8'h3A});
        sb.push_back({2'd3, 8'h3B});
        sb.push_back({2'd0, 8'h0A});
        sb.push_back({2'd0, 8'h0B});
        tick();
        total_cnt++;
        if (in_fire !== 4'b0100) $display("[TB] FAIL wrap_first_grant: got %b, expected 0100", in_fire);
        else pass_cnt++;
        src_left[0] = 2;
        src_data[0] = 8'h0A;
        src_left[3] = 2;
        src_data[3] = 8'h3A;
        drive_inputs();
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            tick();
            if (out_fire) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({obs_sel, obs_data} !== exp)
                    $display("[TB] FAIL wrap_order: got sel=%0d data=%h, expected sel=%0d data=%h", obs_sel, obs_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL wrap_timeout: %0d beats missing, expected 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] exp;
        apply_reset();
        src_left[2] = 100;
        src_data[2] = 8'h50;
        drive_inputs();
        tick();
        total_cnt++;
        if (in_fire !== 4'b0100) $display("[TB] FAIL midrst_grant: got %b, expected 0100", in_fire);
        else pass_cnt++;
        out_ready = 1'b0;
        rst_n = 1'b0;
        src_left[1] = 100;
        src_data[1] = 8'h10;
        src_left[3] = 100;
        src_data[3] = 8'h30;
        drive_inputs();
        tick();
        total_cnt++;
        if (obs_ready !== 4'b0000) $display("[TB] FAIL midrst_in_ready: got %b, expected 0000", obs_ready);
        else pass_cnt++;
        total_cnt++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 8'h00})
            $display("[TB] FAIL midrst_outputs: got valid=%b sel=%0d data=%h, expected valid=0 sel=0 data=00", out_valid, out_sel, out_data);
        else pass_cnt++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive_inputs();
        sb.push_back({2'd1, 8'h10});
        sb.push_back({2'd1, 8'h11});
        sb.push_back({2'd2, 8'h51});
        sb.push_back({2'd2, 8'h52});
        sb.push_back({2'd3, 8'h30});
        sb.push_back({2'd3, 8'h31});
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            tick();
            if (out_fire) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({obs_sel, obs_data} !== exp)
                    $display("[TB] FAIL midrst_order: got sel=%0d data=%h, expected sel=%0d data=%h", obs_sel, obs_data, exp[9:8], exp[7:0]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL midrst_timeout: %0d beats missing, expected 0", sb.size());
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid = '0;
        in_data = '0;
        clear_sources();
        @(posedge clk);
        #1;
        test_reset();
        test_fairness();
        test_early_release();
        test_backpressure();
        test_wrap_around();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
